nibble_collector: RTL and testbench

Sequencer and assembler that sits directly around `input_selector`. It drives that block's select and busy inputs and sweeps a run of consecutive nibble indices. It captures the returned 4-bit `r` each cycle and packs the nibbles into a 64-bit word. The assembled word goes downstream and is flagged by a one-cycle `done` pulse.

---
 rtl/nibble_collector.sv | 131 +++++++++++++
 tb/tb_nibble_collector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_collector.sv
// -----------------------------------------------------------------------------
// nibble_collector
//
// Sequencer/assembler wrapped around the combinational input_selector. On a
// start request it sweeps a run of consecutive nibble indices (main: mod 16,
// registers: mod 64), captures the nibble returned on r each cycle, packs the
// nibbles into a 64-bit word (first nibble in bits 3:0) and publishes the word
// with a one-cycle done pulse.
//
// States
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for start; run parameters latched on acceptance
//   COLLECT | select index presented, r captured into shadow nibble k
//   DONE    | shadow copied to word, done pulses on the following cycle
//
// Ports
//   clk           in   1   sole clock, rising edge
//   reset_L       in   1   asynchronous active-low reset
//   start         in   1   run request, sampled only in IDLE
//   origin        in   1   0 = main data (16 nibbles), 1 = register data (64)
//   baseIdx       in   6   first nibble index (main uses bits 3:0)
//   count         in   4   nibbles to collect, 0 means 16
//   r             in   4   nibble returned by input_selector
//   wBusy         out  1   high while collecting
//   wSelecOrigin  out  1   latched origin
//   wSelecMain    out  4   current main index (0 when not selected)
//   wSelecRegs    out  6   current register index (0 when not selected)
//   word          out  64  assembled result, held until next completion
//   done          out  1   one-cycle pulse, word valid from this cycle
// -----------------------------------------------------------------------------
module nibble_collector (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        start,
  input  logic        origin,
  input  logic [5:0]  baseIdx,
  input  logic [3:0]  count,
  input  logic [3:0]  r,
  output logic        wBusy,
  output logic        wSelecOrigin,
  output logic [3:0]  wSelecMain,
  output logic [5:0]  wSelecRegs,
  output logic [63:0] word,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  runBase;
  logic [4:0]  runTotal;
  logic [4:0]  k;
  logic [63:0] shadow;

  logic [4:0]  kNext;
  logic [5:0]  nextIdx;
  logic [5:0]  capturePos;
  logic [4:0]  acceptTotal;

  // The register index wraps naturally in 6 bits; the main index is simply
  // the low 4 bits of the same sum, which is the mod-16 wrap.
  assign kNext       = k + 5'd1;
  assign nextIdx     = runBase + {1'b0, kNext};
  assign capturePos  = {k[3:0], 2'b00};
  assign acceptTotal = (count == 4'd0) ? 5'd16 : {1'b0, count};

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state        <= IDLE;
      runBase      <= 6'd0;
      runTotal     <= 5'd0;
      k            <= 5'd0;
      shadow       <= 64'd0;
      wBusy        <= 1'b0;
      wSelecOrigin <= 1'b0;
      wSelecMain   <= 4'd0;
      wSelecRegs   <= 6'd0;
      word         <= 64'd0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= COLLECT;
            runBase      <= baseIdx;
            runTotal     <= acceptTotal;
            k            <= 5'd0;
            shadow       <= 64'd0;
            wBusy        <= 1'b1;
            wSelecOrigin <= origin;
            wSelecMain   <= origin ? 4'd0 : baseIdx[3:0];
            wSelecRegs   <= origin ? baseIdx : 6'd0;
          end
        end

        COLLECT: begin
          // r belongs to the index presented during this cycle.
          shadow[capturePos +: 4] <= r;
          k <= kNext;
          if (kNext == runTotal) begin
            state      <= DONE;
            wBusy      <= 1'b0;
            wSelecMain <= 4'd0;
            wSelecRegs <= 6'd0;
          end else begin
            wSelecMain <= wSelecOrigin ? 4'd0 : nextIdx[3:0];
            wSelecRegs <= wSelecOrigin ? nextIdx : 6'd0;
          end
        end

        DONE: begin
          word  <= shadow;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          wBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_collector.sv
module tb_nibble_collector;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        start = 1'b0;
  logic        origin = 1'b0;
  logic [5:0]  baseIdx = 6'd0;
  logic [3:0]  count = 4'd0;
  logic [3:0]  r;
  logic        wBusy;
  logic        wSelecOrigin;
  logic [3:0]  wSelecMain;
  logic [5:0]  wSelecRegs;
  logic [63:0] word;
  logic        done;

  logic [63:0]  mainData = 64'h0123456789abcdef;
  logic [255:0] regsData = 256'h6789abcdef0123456789abcdef0123456789abcdef0123456789abcdef012345;

  int nAsserts = 0;
  int nFails   = 0;
  int doneCount = 0;

  always #5 clk = ~clk;

  nibble_collector dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .start        (start),
    .origin       (origin),
    .baseIdx      (baseIdx),
    .count        (count),
    .r            (r),
    .wBusy        (wBusy),
    .wSelecOrigin (wSelecOrigin),
    .wSelecMain   (wSelecMain),
    .wSelecRegs   (wSelecRegs),
    .word         (word),
    .done         (done)
  );

  // input_selector stand-in: combinational nibble lookup
  assign r = wSelecOrigin ? regsData[{wSelecRegs, 2'b00} +: 4]
                          : mainData[{wSelecMain, 2'b00} +: 4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib(input bit o, input int idx);
    if (o) return regsData[idx*4 +: 4];
    return mainData[idx*4 +: 4];
  endfunction

  // ---------------- behavioural model ----------------
  // A run accepted at edge E0 occupies t = 0..n-1 collecting, t = n idle
  // gap, t = n+1 the done cycle. Another start is accepted once t >= n+1.
  bit          mActive = 1'b0;
  int          mT = 0;
  bit          mOrigin = 1'b0;
  int          mBase = 0;
  int          mN = 0;
  logic [63:0] mRunWord = 64'd0;
  logic [63:0] mHeldWord = 64'd0;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mActive = 1'b0;
      mT = 0;
      mOrigin = 1'b0;
      mHeldWord = 64'd0;
    end else begin
      if ((!mActive || mT >= mN + 1) && start === 1'b1) begin
        mOrigin  = origin;
        mN       = (count == 4'd0) ? 16 : int'(count);
        mBase    = origin ? int'(baseIdx) : int'(baseIdx[3:0]);
        mRunWord = 64'd0;
        for (int j = 0; j < mN; j++)
          mRunWord[j*4 +: 4] = nib(mOrigin, (mBase + j) % (mOrigin ? 64 : 16));
        mT = 0;
        mActive = 1'b1;
      end else if (mActive) begin
        mT++;
        if (mT == mN + 1) mHeldWord = mRunWord;
        if (mT > mN + 1) mActive = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit expBusy;
    bit expDone;
    int expMain;
    int expRegs;
    expBusy = mActive && (mT < mN);
    expDone = mActive && (mT == mN + 1);
    expMain = (expBusy && !mOrigin) ? (mBase + mT) % 16 : 0;
    expRegs = (expBusy && mOrigin) ? (mBase + mT) % 64 : 0;
    check("wBusy", 64'(wBusy), 64'(expBusy));
    check("done", 64'(done), 64'(expDone));
    check("wSelecOrigin", 64'(wSelecOrigin), 64'(mOrigin));
    check("wSelecMain", 64'(wSelecMain), 64'(expMain));
    check("wSelecRegs", 64'(wSelecRegs), 64'(expRegs));
    check("word", word, mHeldWord);
    if (done === 1'b1) doneCount++;
  end

  // ---------------- directed scenarios ----------------
  int selLog[16];
  int nSel;

  task automatic runScen(input bit o, input int b, input int c, input logic [63:0] expWord,
                         input int injectAt, input int resetAt, input string tag,
                         output int lat, output int busyCyc);
    @(negedge clk);
    origin = o; baseIdx = 6'(b); count = 4'(c); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busyCyc = 0; nSel = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (wBusy === 1'b1) begin
        busyCyc++;
        if (nSel < 16) begin
          selLog[nSel] = o ? int'(wSelecRegs) : int'(wSelecMain);
          nSel++;
        end
      end
      if (lat == resetAt) begin
        #2 reset_L = 1'b0;
        #1;
        check({tag, " rst wBusy"}, 64'(wBusy), 64'd0);
        check({tag, " rst wSelecOrigin"}, 64'(wSelecOrigin), 64'd0);
        check({tag, " rst wSelecMain"}, 64'(wSelecMain), 64'd0);
        check({tag, " rst wSelecRegs"}, 64'(wSelecRegs), 64'd0);
        check({tag, " rst word"}, word, 64'd0);
        check({tag, " rst done"}, 64'(done), 64'd0);
        @(negedge clk);
        #2 reset_L = 1'b1;
        break;
      end
      start = (lat == injectAt);
      if (lat == injectAt) begin
        baseIdx = 6'd5; count = 4'd3; origin = ~o;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    start = 1'b0;
    if (resetAt < 0) begin
      check({tag, " done seen"}, 64'(done), 64'd1);
      check({tag, " word"}, word, expWord);
      check({tag, " model word"}, mHeldWord, expWord);
    end
  endtask

  initial begin
    int lat, busyCyc, d0;
    int seqMain[4];
    int seqRegs[4];
    seqMain = '{14, 15, 0, 1};
    seqRegs = '{62, 63, 0, 1};

    repeat (2) @(negedge clk);
    #1;
    check("reset wBusy", 64'(wBusy), 64'd0);
    check("reset word", word, 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset wSelecMain", 64'(wSelecMain), 64'd0);
    @(negedge clk);
    #2 reset_L = 1'b1;
    @(negedge clk);

    // 1: main full sweep
    runScen(1'b0, 0, 0, 64'h0123456789abcdef, -1, -1, "s1", lat, busyCyc);
    check("s1 latency", 64'(lat), 64'd17);
    check("s1 busy cycles", 64'(busyCyc), 64'd16);

    // 2: main wrap
    runScen(1'b0, 14, 4, 64'h000000000000ef01, -1, -1, "s2", lat, busyCyc);
    check("s2 latency", 64'(lat), 64'd5);
    for (int i = 0; i < 4; i++) check("s2 wSelecMain seq", 64'(selLog[i]), 64'(seqMain[i]));

    // 3: regs wrap
    runScen(1'b1, 62, 4, 64'h0000000000004567, -1, -1, "s3", lat, busyCyc);
    for (int i = 0; i < 4; i++) check("s3 wSelecRegs seq", 64'(selLog[i]), 64'(seqRegs[i]));

    // 4: regs single nibble
    runScen(1'b1, 0, 1, 64'h5, -1, -1, "s4", lat, busyCyc);
    check("s4 latency", 64'(lat), 64'd2);
    check("s4 busy cycles", 64'(busyCyc), 64'd1);

    // 5: start while busy is ignored
    @(negedge clk); #1 d0 = doneCount;
    runScen(1'b0, 0, 0, 64'h0123456789abcdef, 3, -1, "s5", lat, busyCyc);
    check("s5 latency", 64'(lat), 64'd17);
    repeat (25) @(negedge clk);
    #1 check("s5 done count", 64'(doneCount - d0), 64'd1);

    // 6: reset mid-run, then a fresh run
    @(negedge clk); #1 d0 = doneCount;
    runScen(1'b0, 0, 0, 64'h0, -1, 5, "s6", lat, busyCyc);
    repeat (20) @(negedge clk);
    #1 check("s6 no done", 64'(doneCount - d0), 64'd0);
    runScen(1'b0, 14, 4, 64'h000000000000ef01, -1, -1, "s6b", lat, busyCyc);
    check("s6b latency", 64'(lat), 64'd5);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) == 0);
      origin  = 1'($urandom);
      baseIdx = 6'($urandom);
      count   = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_L = 1'b0;
        #5 reset_L = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
